// File: rtl/pokey_serin_pkg.sv
// Shared types and constants for the POKEY serial-input receiver.
// No logic; latency and backpressure are properties of the modules that import it.
package pokey_serin_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_W         = 8;

endpackage

// File: rtl/pokey_sync2.sv
// Two-flop synchronizer for the SID pin, idling high; 2 clk latency.
// No backpressure: samples every clk regardless of the slow-clock enable.
module pokey_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pokey_serin_rx.sv
// SERIN async deframer (start, 8 data LSB first, stop); byte/flags update on the stop tick.
// No backpressure: a byte completing while one is unread overwrites it and sets overrun. POKEY_SERIN_SYNC_EN adds a 2-flop SID synchronizer.
module pokey_serin_rx
    import pokey_serin_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enp,
    input  logic              sample_tick,
    input  logic              sid,
    input  logic              rd_ack,
    input  logic              skres,
    output logic [DATA_W-1:0] serin,
    output logic              data_valid,
    output logic              rx_done,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int            TW      = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    rx_state_t         r_state;
    logic [TW-1:0]     r_tcnt;
    logic [2:0]        r_bcnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_serin;
    logic              r_data_valid;
    logic              r_rx_done;
    logic              r_frame_err;
    logic              r_overrun;
    logic              w_sid;
    logic              w_tick;

`ifdef POKEY_SERIN_SYNC_EN
    pokey_sync2 u_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .i_d   (sid),
        .o_q   (w_sid)
    );
`else
    assign w_sid = sid;
`endif

    assign w_tick = enp & sample_tick;

    // Clears are written before sets so a same-clk set overrides the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_tcnt       <= '0;
            r_bcnt       <= '0;
            r_shift      <= '0;
            r_serin      <= '0;
            r_data_valid <= 1'b0;
            r_rx_done    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (rd_ack) begin
                r_data_valid <= 1'b0;
            end
            if (skres) begin
                r_frame_err <= 1'b0;
                r_overrun   <= 1'b0;
            end
            if (w_tick) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_sid) begin
                            r_state <= ST_START;
                            r_tcnt  <= '0;
                        end
                    end
                    ST_START: begin
                        if (r_tcnt == HALF_M1) begin
                            r_tcnt <= '0;
                            if (!w_sid) begin
                                r_state <= ST_DATA;
                                r_bcnt  <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (r_tcnt == FULL_M1) begin
                            r_tcnt  <= '0;
                            r_shift <= {w_sid, r_shift[DATA_W-1:1]};
                            r_bcnt  <= r_bcnt + 3'd1;
                            if (r_bcnt == 3'd7) begin
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (r_tcnt == FULL_M1) begin
                            r_tcnt       <= '0;
                            r_state      <= ST_IDLE;
                            r_serin      <= r_shift;
                            r_data_valid <= 1'b1;
                            r_rx_done    <= 1'b1;
                            if (!w_sid) begin
                                r_frame_err <= 1'b1;
                            end
                            if (r_data_valid && !rd_ack) begin
                                r_overrun <= 1'b1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign serin      = r_serin;
    assign data_valid = r_data_valid;
    assign rx_done    = r_rx_done;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pokey_serin_rx.sv
// Directed bench for pokey_serin_rx: table of whole frames plus hand sequences
// for reset, false start, skres priority and mid-frame reset.
module tb_pokey_serin_rx;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enp;
    logic       sample_tick;
    logic       sid;
    logic       rd_ack;
    logic       skres;
    logic [7:0] serin;
    logic       data_valid;
    logic       rx_done;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    pokey_serin_rx #(.OVERSAMPLE(OS)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enp         (enp),
        .sample_tick (sample_tick),
        .sid         (sid),
        .rd_ack      (rd_ack),
        .skres       (skres),
        .serin       (serin),
        .data_valid  (data_valid),
        .rx_done     (rx_done),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         div;
        logic       pre_rd;
        logic       pre_sk;
        logic       ack_done;
        logic       sk_done;
        logic [7:0] exp_serin;
        logic       exp_dv;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    vec_t vecs[9];

    int n_tests   = 0;
    int n_fail    = 0;
    int done_cnt  = 0;
    int done_tick = -1;
    int tick_idx  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clk with the given inputs; outputs are sampled 1ns after the edge.
    task automatic clk1(input logic e, input logic st, input logic s, input logic ra, input logic sk);
        enp = e; sample_tick = st; sid = s; rd_ack = ra; skres = sk;
        @(posedge clk);
        #1;
        if (rx_done) begin
            done_cnt++;
            done_tick = tick_idx;
        end
        rd_ack = 1'b0;
        skres  = 1'b0;
    endtask

    // One effective tick, preceded by (div-1) clks of sample_tick without enp.
    task automatic tick(input logic s, input int div, input logic ra, input logic sk);
        for (int k = 1; k < div; k++) clk1(1'b0, 1'b1, s, 1'b0, 1'b0);
        clk1(1'b1, 1'b1, s, ra, sk);
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input logic stop, input int idx);
        if (idx < OS)      return 1'b0;
        if (idx < 9 * OS)  return d[(idx - OS) / OS];
        return stop;
    endfunction

    // Ticks 0..152 carry the frame (detection at tick 0), then idle-high ticks.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int div,
                              input logic ack_done, input logic sk_done);
        done_cnt  = 0;
        done_tick = -1;
        for (int i = 0; i <= 152; i++) begin
            tick_idx = i;
            tick(frame_bit(d, stop, i), div, ack_done && (i == 152), sk_done && (i == 152));
        end
        for (int i = 153; i < 157; i++) begin
            tick_idx = i;
            tick(1'b1, div, 1'b0, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " serin"},      32'(serin),      32'h00);
        check({tag, " data_valid"}, 32'(data_valid), 32'd0);
        check({tag, " rx_done"},    32'(rx_done),    32'd0);
        check({tag, " frame_err"},  32'(frame_err),  32'd0);
        check({tag, " overrun"},    32'(overrun),    32'd0);
        check({tag, " busy"},       32'(busy),       32'd0);
    endtask

    initial begin
        //          data   stp div rd sk ack skd  serin  dv fe ov
        vecs[0] = '{8'hA5, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h11, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h22, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{8'h11, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h22, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'h5A, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h3C, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{8'h3C, 1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0};

        reset_n = 1'b0;
        enp = 1'b0; sample_tick = 1'b0; sid = 1'b1; rd_ack = 1'b0; skres = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        clk1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        clk1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("idle busy", 32'(busy), 32'd0);

        clk1(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rd_ack empty data_valid", 32'(data_valid), 32'd0);
        check("rd_ack empty serin",      32'(serin),      32'h00);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].pre_rd || vecs[v].pre_sk)
                clk1(1'b1, 1'b0, 1'b1, vecs[v].pre_rd, vecs[v].pre_sk);
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].div, vecs[v].ack_done, vecs[v].sk_done);
            check($sformatf("vec%0d serin", v),      32'(serin),      32'(vecs[v].exp_serin));
            check($sformatf("vec%0d data_valid", v), 32'(data_valid), 32'(vecs[v].exp_dv));
            check($sformatf("vec%0d frame_err", v),  32'(frame_err),  32'(vecs[v].exp_fe));
            check($sformatf("vec%0d overrun", v),    32'(overrun),    32'(vecs[v].exp_ov));
            check($sformatf("vec%0d rx_done count", v), 32'(done_cnt),  32'd1);
            check($sformatf("vec%0d rx_done tick", v),  32'(done_tick), 32'd152);
            check($sformatf("vec%0d busy after", v),    32'(busy),      32'd0);
        end

        clk1(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        check("skres frame_err", 32'(frame_err),  32'd0);
        check("skres overrun",   32'(overrun),    32'd0);
        check("skres keeps dv",  32'(data_valid), 32'd1);

        done_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick_idx = i;
            tick((i < 4) ? 1'b0 : 1'b1, 1, 1'b0, 1'b0);
            if (i == 0) check("false start busy on", 32'(busy), 32'd1);
            if (i == 7) check("false start busy held", 32'(busy), 32'd1);
            if (i == 8) check("false start busy off", 32'(busy), 32'd0);
        end
        check("false start rx_done", 32'(done_cnt),  32'd0);
        check("false start fe",      32'(frame_err), 32'd0);
        check("false start ov",      32'(overrun),   32'd0);
        check("false start serin",   32'(serin),     32'h3C);

        for (int i = 0; i < 76; i++) begin
            tick_idx = i;
            tick(frame_bit(8'hFF, 1'b1, i), 1, 1'b0, 1'b0);
        end
        check("midframe busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #2;
        check_reset_outputs("midframe reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clk1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        clk1(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("post reset busy", 32'(busy), 32'd0);
        send_frame(8'h0F, 1'b1, 1, 1'b0, 1'b0);
        check("post reset serin",      32'(serin),      32'h0F);
        check("post reset data_valid", 32'(data_valid), 32'd1);
        check("post reset frame_err",  32'(frame_err),  32'd0);
        check("post reset overrun",    32'(overrun),    32'd0);
        check("post reset rx_done count", 32'(done_cnt),  32'd1);
        check("post reset rx_done tick",  32'(done_tick), 32'd152);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pokey_serin_rx.md
# pokey_serin_rx

Serial-input receiver for the POKEY serial port: the receive-side counterpart of the SEROUT shift-register chain. Samples the SID line on oversampling ticks from the channel-4 timer and deframes asynchronous frames: start bit, 8 data bits LSB first, stop bit. Completed bytes go to the SERIN holding register. Raises the serial-input-ready interrupt request and the SKSTAT frame-error and overrun flags.

## Interface
- `OVERSAMPLE`, default 16: `sample_tick` pulses per bit period; even, 4..16.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `enp` in 1: slow-clock phase enable; all state except the synchronizer advances only when `enp`=1.
- `sample_tick` in 1: oversample tick from the channel-4 timer; counts only when `enp`=1.
- `sid` in 1: serial data in; idle high.
- `rd_ack` in 1: one-clk pulse on a SERIN read; clears `data_valid`.
- `skres` in 1: one-clk pulse on an SKRES write; clears `frame_err` and `overrun`.
- `serin` out 8: last received byte.
- `data_valid` out 1: byte waiting, not yet read.
- `rx_done` out 1: one-clk pulse when a frame completes; serial-input IRQ source.
- `frame_err` out 1: sticky; stop bit sampled low.
- `overrun` out 1: sticky; a frame completed while `data_valid`=1.
- `busy` out 1: receiver not IDLE.

## Operation
- An event ("tick") is `enp` & `sample_tick` in the same clk.
- State machine:
  - IDLE: on a tick with synced `sid`=0, go to START and clear `tcnt`.
  - START: at `tcnt`=OVERSAMPLE/2-1 on a tick, check `sid`.
    - `sid`=0: go to DATA and clear `tcnt` and `bcnt`.
    - `sid`=1: false start; return to IDLE with no flags changed.
  - DATA: at `tcnt`=OVERSAMPLE-1 on a tick, shift `sid` into the shift register MSB (shift right) and increment `bcnt`. After `bcnt`=7 is sampled, go to STOP.
  - STOP: at `tcnt`=OVERSAMPLE-1 on a tick, complete the frame and return to IDLE. A new start can be detected from the next tick.
- On frame completion:
  - `serin` loads the shift register.
  - `data_valid` is set.
  - `rx_done` pulses.
  - `frame_err` is set if `sid`=0.
  - `overrun` is set if `data_valid` was already 1 and `rd_ack` is not present in the same clk. `serin` is still overwritten.
- `tcnt` is log2(OVERSAMPLE) bits and clears whenever its compare value is reached. `bcnt` is 3 bits.
- Simultaneous events:
  - Completion with `rd_ack` in the same clk: `data_valid` stays 1, no overrun.
  - Set and `skres` in the same clk: set wins.
- `rd_ack` with `data_valid`=0 has no effect. `serin` is never cleared by a read.

## Timing
- Reset values: `serin`=0x00, `data_valid`=0, `rx_done`=0, `frame_err`=0, `overrun`=0, `busy`=0, state IDLE, shift register 0. Reset mid-frame aborts immediately, with no partial byte.
- Let the detection tick be T0 (tick count relative to it). Frame milestones:
  - Start verify: T0+OVERSAMPLE/2.
  - Data bit i: T0+OVERSAMPLE/2+OVERSAMPLE·(i+1).
  - Stop bit: T0+OVERSAMPLE/2+9·OVERSAMPLE, i.e. T0+152 for OVERSAMPLE=16.
- Outputs update on the clk edge that registers the stop tick. `rx_done` is high exactly one clk.
- `busy` is high from the clk after detection until the clk after completion or a false start.
- `enp`=0 freezes all counters and state. `sample_tick` without `enp` is ignored.

## Configuration
- `POKEY_SERIN_SYNC_EN`:
  - Defined: `sid` passes through a two-flop synchronizer clocked every clk, independent of `enp`. This adds 2 clk latency before sampling; all tick-relative timing is unchanged.
  - Undefined: `sid` is used directly, for a synchronous source.

## Structure
- Package `pokey_serin_pkg` holds:
  - state enum (IDLE, START, DATA, STOP);
  - default OVERSAMPLE constant;
  - data width constant (8).
- Sub-module `pokey_sync2`: two-flop synchronizer with asynchronous active-low reset, reset value 1. It is instantiated only under `POKEY_SERIN_SYNC_EN`.
- Counters, the shift register and the flags stay in the top module.

## Test plan
- Frame 0xA5 with a good stop bit, ticks every clk with `enp`=1, OVERSAMPLE=16 -> `serin`=0xA5, `data_valid`=1, one-clk `rx_done` 152 ticks after detection, `frame_err`=0.
- `sid` low for 4 ticks then high -> false start; back to IDLE, `busy` drops, no `rx_done`, no flags.
- Frame 0x3C with the stop bit low -> `serin`=0x3C, `frame_err`=1 and held until `skres`. `skres` asserted the same clk as a second framing error -> `frame_err` stays 1.
- Two frames, 0x11 then 0x22, with no `rd_ack` -> `serin`=0x22, `overrun`=1. Repeat with `rd_ack` in the completion clk of 0x22 -> `overrun`=0, `data_valid`=1.
- `enp` toggling 1-of-3 clks during frame 0x5A -> same byte received; completion tick count is unchanged.
- `reset_n` low after data bit 3 of frame 0xFF -> all outputs at reset values. The next full frame, 0x0F, is received correctly.
